// File: rtl/param_hdr_parser_if.sv
// AXI-Stream header-capture port bundle for param_hdr_parser.
// The parser takes the slave side; the traffic source takes the master side.
interface param_hdr_parser_if #(
    parameter int DATA_W  = 256,
    parameter int TUSER_W = 128
);
    logic [DATA_W-1:0]   tdata;
    logic [TUSER_W-1:0]  tuser;
    logic [DATA_W/8-1:0] tkeep;
    logic                tvalid;
    logic                tlast;
    logic                tready;

    modport master (output tdata, tuser, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tuser, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/param_hdr_parser.sv
// Table-driven packet header parser: captures up to NUM_SEGS beats, extracts fields into PHV containers.
// Define PARSER_STATS_EN to add the pkt_cnt / trunc_cnt statistics ports.
module param_hdr_parser #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_SEGS             = 4,
    parameter int NUM_ACTS             = 10,
    parameter int NUM_CONT             = 8,
    parameter int TBL_ADDR_W           = 5,
    localparam int PKT_HDR_LEN         = NUM_CONT*96+256
) (
    input  logic                       clk,
    input  logic                       aresetn,
    param_hdr_parser_if.slave          s_axis,
    output logic                       parser_valid,
    output logic [PKT_HDR_LEN-1:0]     pkt_hdr_vec,
    input  logic                       stg_ready_in,
    input  logic                       tbl_wr_en,
    input  logic [TBL_ADDR_W-1:0]      tbl_wr_addr,
    input  logic [NUM_ACTS*16-1:0]     tbl_wr_data
`ifdef PARSER_STATS_EN
    ,
    output logic [31:0]                pkt_cnt,
    output logic [31:0]                trunc_cnt
`endif
);
    localparam int DW     = C_S_AXIS_DATA_WIDTH;
    localparam int NBYTES = NUM_SEGS*DW/8;
    localparam int BIDX_W = $clog2(NBYTES);
    localparam int SEG_W  = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1;
    localparam int ENT_W  = NUM_ACTS*16;

    typedef enum logic [2:0] {IDLE, CAPTURE, FLUSH, EXTRACT, OUTPUT} state_t;

    state_t                          state;
    logic [NUM_SEGS-1:0][DW-1:0]     hdr_buf;
    logic [NBYTES-1:0][7:0]          hdr_b;
    logic [SEG_W-1:0]                seg_cnt;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser_l;
    logic [ENT_W-1:0]                tbl [2**TBL_ADDR_W];
    logic [ENT_W-1:0]                entry;
    logic [11:0]                     vlan_id;
    logic [NUM_CONT-1:0][15:0]       c2;
    logic [NUM_CONT-1:0][31:0]       c4;
    logic [NUM_CONT-1:0][47:0]       c6;
    logic [PKT_HDR_LEN-1:0]          vec_next;
    logic                            beat;
    logic                            unused_tkeep;

    assign unused_tkeep = ^s_axis.tkeep;
    assign beat         = s_axis.tvalid && s_axis.tready;
    assign hdr_b        = hdr_buf;
    assign vlan_id      = {hdr_b[15], hdr_b[14][7:4]};
    assign entry        = tbl[vlan_id[4 +: TBL_ADDR_W]];

    // Action table: plain registers so reset can clear every entry.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            for (int i = 0; i < 2**TBL_ADDR_W; i++) tbl[i] <= '0;
        end else if (tbl_wr_en) begin
            tbl[tbl_wr_addr] <= tbl_wr_data;
        end
    end

    // Ascending action order means the highest-indexed action targeting a container wins.
    always_comb begin
        logic [15:0] act;
        logic [47:0] fld;
        logic [31:0] idx;
        c2  = '0;
        c4  = '0;
        c6  = '0;
        act = '0;
        fld = '0;
        idx = '0;
        for (int a = 0; a < NUM_ACTS; a++) begin
            act = entry[a*16 +: 16];
            fld = '0;
            for (int k = 0; k < 6; k++) begin
                idx = 32'(act[15:8]) + 32'(k);
                fld = {fld[39:0], (idx < 32'(NBYTES)) ? hdr_b[idx[BIDX_W-1:0]] : 8'h00};
            end
            // fld holds six bytes from the offset; narrower containers keep its leading bytes
            for (int c = 0; c < NUM_CONT; c++) begin
                if (act[0] && (32'(act[7:5]) == 32'(c))) begin
                    case (act[4:3])
                        2'b01:   c2[c] = fld[47:32];
                        2'b10:   c4[c] = fld[47:16];
                        2'b11:   c6[c] = fld;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign vec_next = {c6, c4, c2, 115'b0, vlan_id, 1'b0, tuser_l};

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state         <= IDLE;
            s_axis.tready <= 1'b1;
            parser_valid  <= 1'b0;
            pkt_hdr_vec   <= '0;
            hdr_buf       <= '0;
            seg_cnt       <= '0;
            tuser_l       <= '0;
`ifdef PARSER_STATS_EN
            pkt_cnt       <= '0;
            trunc_cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (beat) begin
                    hdr_buf    <= '0;
                    hdr_buf[0] <= s_axis.tdata;
                    tuser_l    <= s_axis.tuser;
                    seg_cnt    <= SEG_W'(1);
                    if (s_axis.tlast) begin
                        state         <= EXTRACT;
                        s_axis.tready <= 1'b0;
                    end else if (NUM_SEGS == 1) begin
                        state <= FLUSH;
`ifdef PARSER_STATS_EN
                        trunc_cnt <= trunc_cnt + 32'd1;
`endif
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: if (beat) begin
                    hdr_buf[seg_cnt] <= s_axis.tdata;
                    seg_cnt          <= seg_cnt + 1'b1;
                    if (s_axis.tlast) begin
                        state         <= EXTRACT;
                        s_axis.tready <= 1'b0;
                    end else if (32'(seg_cnt) == 32'(NUM_SEGS-1)) begin
                        state <= FLUSH;
`ifdef PARSER_STATS_EN
                        trunc_cnt <= trunc_cnt + 32'd1;
`endif
                    end
                end
                FLUSH: if (beat && s_axis.tlast) begin
                    state         <= EXTRACT;
                    s_axis.tready <= 1'b0;
                end
                EXTRACT: begin
                    pkt_hdr_vec  <= vec_next;
                    parser_valid <= 1'b1;
                    state        <= OUTPUT;
                end
                OUTPUT: if (stg_ready_in) begin
                    parser_valid  <= 1'b0;
                    s_axis.tready <= 1'b1;
                    state         <= IDLE;
`ifdef PARSER_STATS_EN
                    pkt_cnt <= pkt_cnt + 32'd1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_param_hdr_parser.sv
// Self-checking bench for param_hdr_parser: constant vector table, directed corner sequences,
// and randomized packets checked against a byte-level reference model.
module tb_param_hdr_parser;
    localparam int DW     = 256;
    localparam int TUW    = 128;
    localparam int NSEG   = 4;
    localparam int NACT   = 10;
    localparam int NCONT  = 8;
    localparam int AW     = 5;
    localparam int VW     = NCONT*96+256;
    localparam int BPB    = DW/8;
    localparam int NBYTES = NSEG*BPB;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    param_hdr_parser_if #(.DATA_W(DW), .TUSER_W(TUW)) s_axis ();
    logic             parser_valid;
    logic [VW-1:0]    pkt_hdr_vec;
    logic             stg_ready_in;
    logic             tbl_wr_en;
    logic [AW-1:0]    tbl_wr_addr;
    logic [NACT*16-1:0] tbl_wr_data;
`ifdef PARSER_STATS_EN
    logic [31:0] pkt_cnt, trunc_cnt;
`endif

    param_hdr_parser #(
        .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(TUW), .NUM_SEGS(NSEG),
        .NUM_ACTS(NACT), .NUM_CONT(NCONT), .TBL_ADDR_W(AW)
    ) dut (
        .clk(clk), .aresetn(aresetn), .s_axis(s_axis),
        .parser_valid(parser_valid), .pkt_hdr_vec(pkt_hdr_vec), .stg_ready_in(stg_ready_in),
        .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data)
`ifdef PARSER_STATS_EN
        , .pkt_cnt(pkt_cnt), .trunc_cnt(trunc_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;
    int n_out = 0;
    int n_trunc = 0;
    int last_stalls = 0;
    logic [DW-1:0]       pkt [$];
    logic [TUW-1:0]      pkt_tuser;
    logic [NACT*16-1:0]  tbl_m [2**AW];
    logic [VW-1:0]       got_vec;

    typedef struct {
        string       nm;
        logic [15:0] act;
        int          pos;
        int          w;
        logic [47:0] exp;
    } vec_t;
    vec_t tv [8];

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        int w;
        w = 0;
        checks++;
        if (got !== exp) begin
            errors++;
            for (int i = VW/64-1; i >= 0; i--) if (got[i*64 +: 64] !== exp[i*64 +: 64]) w = i;
            $display("FAIL %s: word %0d got %h expected %h", nm, w, got[w*64 +: 64], exp[w*64 +: 64]);
        end
    endtask

    // Reference model: header byte j is byte j of the packet if it lies in the first NSEG beats.
    function automatic logic [7:0] hbyte(input int j);
        logic [DW-1:0] b;
        if (j >= NBYTES || j/BPB >= pkt.size()) return 8'h00;
        b = pkt[j/BPB];
        return b[(j%BPB)*8 +: 8];
    endfunction

    function automatic logic [VW-1:0] model_vec();
        logic [VW-1:0]      v;
        logic [11:0]        vlan;
        logic [7:0]         b14;
        logic [NACT*16-1:0] ent;
        logic [15:0]        act;
        logic [47:0]        val;
        int nbytes, ci, base;
        v    = '0;
        b14  = hbyte(14);
        vlan = {hbyte(15), b14[7:4]};
        ent  = tbl_m[vlan[8:4]];
        for (int a = 0; a < NACT; a++) begin
            act    = ent[a*16 +: 16];
            ci     = int'(act[7:5]);
            nbytes = 2*int'(act[4:3]);
            if (act[0] && nbytes != 0 && ci < NCONT) begin
                val = '0;
                for (int k = 0; k < nbytes; k++) val = (val << 8) | 48'(hbyte(int'(act[15:8]) + k));
                base = (nbytes == 2) ? 256 + 16*ci : (nbytes == 4) ? 384 + 32*ci : 640 + 48*ci;
                for (int i = 0; i < nbytes*8; i++) v[base+i] = val[i];
            end
        end
        v[127:0]   = pkt_tuser;
        v[140:129] = vlan;
        return v;
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] b;
        for (int i = 0; i < DW/32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [NACT*16-1:0] rand_entry();
        logic [NACT*16-1:0] e;
        logic [15:0] a;
        for (int i = 0; i < NACT; i++) begin
            a       = 16'($urandom);
            a[15:8] = 8'($urandom_range(0, 140));
            a[0]    = ($urandom % 4) != 0;
            e[i*16 +: 16] = a;
        end
        return e;
    endfunction

    task automatic pattern_pkt(input int n);
        logic [DW-1:0] b;
        pkt.delete();
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < BPB; j++) b[j*8 +: 8] = 8'(i*BPB + j + 1);
            pkt.push_back(b);
        end
        pkt_tuser = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic rand_pkt(input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(rand_beat());
        pkt_tuser = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic set_vlan(input logic [11:0] v);
        logic [DW-1:0] b;
        b = pkt[0];
        b[116 +: 12] = v;
        pkt[0] = b;
    endtask

    task automatic tbl_write(input logic [AW-1:0] a, input logic [NACT*16-1:0] d);
        @(negedge clk);
        tbl_wr_en = 1'b1; tbl_wr_addr = a; tbl_wr_data = d;
        @(negedge clk);
        tbl_wr_en = 1'b0;
        tbl_m[a] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        aresetn = 1'b0; s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0; stg_ready_in = 1'b1;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        for (int i = 0; i < 2**AW; i++) tbl_m[i] = '0;
        n_out = 0;
        n_trunc = 0;
    endtask

    // Returns just after the clock edge that accepts the final beat.
    task automatic send_pkt(input bit gaps, input bit with_last, output int stalls);
        int guard;
        stalls = 0;
        for (int i = 0; i < pkt.size(); i++) begin
            @(negedge clk);
            if (gaps) while ($urandom % 3 == 0) @(negedge clk);
            s_axis.tdata  = pkt[i];
            s_axis.tuser  = (i == 0) ? pkt_tuser : {$urandom, $urandom, $urandom, $urandom};
            s_axis.tlast  = with_last && (i == pkt.size()-1);
            s_axis.tvalid = 1'b1;
            guard = 0;
            while (!s_axis.tready && guard < 50) begin
                @(negedge clk);
                guard++;
                stalls++;
            end
            if (!s_axis.tready) begin
                checks++; errors++;
                $display("FAIL send_ready: tready stuck at 0 on beat %0d", i);
            end
            @(posedge clk);
            #1 s_axis.tvalid = 1'b0;
            s_axis.tlast = 1'b0;
        end
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!parser_valid && lat < 40);
        if (!parser_valid) begin
            checks++; errors++;
            $display("FAIL out_timeout: parser_valid 0 after %0d cycles", lat);
        end
    endtask

    // Called at the negedge where parser_valid is first seen high.
    task automatic finish_out(input int hold);
        logic [VW-1:0] snap;
        snap = pkt_hdr_vec;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_valid", parser_valid, 1);
            chk("bp_tready", s_axis.tready, 0);
            chk_vec("bp_stable", pkt_hdr_vec, snap);
        end
        stg_ready_in = 1'b1;
        @(negedge clk);
        chk("hs_valid_low", parser_valid, 0);
        chk("hs_tready_high", s_axis.tready, 1);
        n_out++;
    endtask

    task automatic do_pkt(input string nm, input int hold, input bit gaps);
        logic [VW-1:0] exp;
        int lat, stalls;
        exp = model_vec();
        if (pkt.size() > NSEG) n_trunc++;
        stg_ready_in = (hold == 0);
        send_pkt(gaps, 1'b1, stalls);
        wait_out(lat);
        chk({nm, "_lat"}, lat, 2);
        chk_vec(nm, pkt_hdr_vec, exp);
        got_vec = pkt_hdr_vec;
        last_stalls = stalls;
        finish_out(hold);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NACT*16-1:0] e, e_old, e_new;
        logic [VW-1:0]      exp;
        logic [47:0]        g;
        int stalls, quiet;

        tv[0] = '{"x6_c2_o0",  {8'd0,   3'd2, 2'b11, 2'b00, 1'b1}, 736, 48, 48'h010203040506};
        tv[1] = '{"x2_c0_o3",  {8'd3,   3'd0, 2'b01, 2'b00, 1'b1}, 256, 16, 48'h0405};
        tv[2] = '{"x4_c7_o28", {8'd28,  3'd7, 2'b10, 2'b00, 1'b1}, 608, 32, 48'h1D1E1F20};
        tv[3] = '{"x2_c5_o31", {8'd31,  3'd5, 2'b01, 2'b00, 1'b1}, 336, 16, 48'h2000};
        tv[4] = '{"x6_c0_o12", {8'd12,  3'd0, 2'b11, 2'b00, 1'b1}, 640, 48, 48'h0D0E0F001112};
        tv[5] = '{"type_none", {8'd0,   3'd1, 2'b00, 2'b00, 1'b1}, 272, 16, 48'h0};
        tv[6] = '{"not_valid", {8'd0,   3'd3, 2'b10, 2'b00, 1'b0}, 480, 32, 48'h0};
        tv[7] = '{"x6_c7_o26", {8'd26,  3'd7, 2'b11, 2'b00, 1'b1}, 976, 48, 48'h1B1C1D1E1F20};

        s_axis.tdata = '0; s_axis.tuser = '0; s_axis.tkeep = '1;
        s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0;
        stg_ready_in = 1'b1; tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_data = '0;
        do_reset();
        @(negedge clk);
        chk("rst_valid", parser_valid, 0);
        chk("rst_tready", s_axis.tready, 1);
        chk_vec("rst_vec", pkt_hdr_vec, '0);

        // Two-beat packet, vlan 5, empty table
        rand_pkt(2); set_vlan(12'd5);
        do_pkt("empty_tbl", 0, 0);
        chk("empty_cont", got_vec[VW-1:256] == '0, 1);
        chk("empty_vlan", got_vec[140:129], 5);
        chk("empty_tuser", got_vec[127:0], pkt_tuser);

        // Single-action vectors on a one-beat counting-pattern packet at table address 0
        for (int i = 0; i < 8; i++) begin
            e = '0;
            e[15:0] = tv[i].act;
            tbl_write('0, e);
            pattern_pkt(1); set_vlan(12'h000);
            do_pkt(tv[i].nm, 0, 0);
            g = 48'(got_vec >> tv[i].pos);
            if (tv[i].w < 48) g = g & ((48'h1 << tv[i].w) - 48'h1);
            chk({tv[i].nm, "_field"}, g, tv[i].exp);
        end

        // Conflicting actions and buffer-edge offsets; vlan of this pattern selects entry 16
        e = '0;
        e[1*16 +: 16] = {8'd0,   3'd0, 2'b01, 2'b00, 1'b1};
        e[3*16 +: 16] = {8'd200, 3'd4, 2'b10, 2'b00, 1'b1};
        e[7*16 +: 16] = {8'd2,   3'd0, 2'b01, 2'b00, 1'b1};
        e[9*16 +: 16] = {8'd125, 3'd5, 2'b10, 2'b00, 1'b1};
        tbl_write(5'd16, e);
        pattern_pkt(4);
        do_pkt("conflict", 0, 0);
        chk("conflict_c2_0", got_vec[256 +: 16], 16'h0304);
        chk("oob_c4_4", got_vec[512 +: 32], 32'h0);
        chk("edge_c4_5", got_vec[544 +: 32], 32'h7E7F8000);

        // Truncation: exactly NSEG beats, then NSEG+3 beats
        for (int i = 0; i < 2**AW; i++) tbl_write(AW'(i), rand_entry());
        rand_pkt(NSEG);
        do_pkt("full_segs", 0, 0);
        rand_pkt(7);
        do_pkt("trunc7", 0, 0);
        chk("trunc7_stalls", last_stalls, 0);
        quiet = 1;
        repeat (3) begin
            @(negedge clk);
            if (parser_valid) quiet = 0;
        end
        chk("trunc7_one_out", quiet, 1);
`ifdef PARSER_STATS_EN
        chk("trunc7_cnt", trunc_cnt, 1);
`endif

        // Output back-pressure for 10 cycles
        rand_pkt(3);
        do_pkt("backpressure", 10, 0);

        // Table write during EXTRACT to the address being read
        e_old = rand_entry(); e_new = rand_entry();
        rand_pkt(1); set_vlan(12'h070);
        tbl_write(5'd7, e_old);
        exp = model_vec();
        stg_ready_in = 1'b1;
        send_pkt(0, 1'b1, stalls);
        @(negedge clk);
        tbl_wr_en = 1'b1; tbl_wr_addr = 5'd7; tbl_wr_data = e_new;
        @(negedge clk);
        tbl_wr_en = 1'b0;
        tbl_m[7] = e_new;
        chk("wr_ext_valid", parser_valid, 1);
        chk_vec("wr_ext_old", pkt_hdr_vec, exp);
        finish_out(0);
        do_pkt("wr_ext_new", 0, 0);

        // Reset after beat 1 of a 3-beat packet
        e = '0;
        e[15:0] = {8'd0, 3'd1, 2'b11, 2'b00, 1'b1};
        tbl_write('0, e);
        rand_pkt(3); set_vlan(12'h000);
        pkt.delete(2);
        send_pkt(0, 1'b0, stalls);
        do_reset();
        quiet = 1;
        repeat (6) begin
            @(negedge clk);
            if (parser_valid) quiet = 0;
        end
        chk("midrst_no_out", quiet, 1);
        rand_pkt(1); set_vlan(12'h000);
        do_pkt("midrst_tail", 0, 0);
        chk("midrst_tbl_zero", got_vec[VW-1:256] == '0, 1);
        rand_pkt(2); set_vlan(12'd5);
        do_pkt("midrst_next", 0, 0);
        chk("midrst_vlan", got_vec[140:129], 5);
        chk("midrst_tuser", got_vec[127:0], pkt_tuser);

        // Randomized traffic against the model
        for (int i = 0; i < 2**AW; i++) tbl_write(AW'(i), rand_entry());
        for (int r = 0; r < 30; r++) begin
            rand_pkt($urandom_range(1, 7));
            if ($urandom % 3 == 0) tbl_write(AW'($urandom), rand_entry());
            do_pkt("rand", $urandom_range(0, 3), 1);
        end
`ifdef PARSER_STATS_EN
        chk("pkt_cnt", pkt_cnt, n_out);
        chk("trunc_cnt", trunc_cnt, n_trunc);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/param_hdr_parser.md
PARAM_HDR_PARSER -- requirements
Module: param_hdr_parser

Interface
REQ-001 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256, the data-bus width in bits (multiple of 8).
REQ-002 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, the tuser width.
REQ-003 SHALL have parameter NUM_SEGS, default 4, range 1-8, the maximum number of header beats captured.
REQ-004 SHALL have parameter NUM_ACTS, default 10, range 1-10, the number of parse actions per table entry.
REQ-005 SHALL have parameter NUM_CONT, default 8, range 1-8, the number of containers per size class (2B, 4B, 6B).
REQ-006 SHALL have parameter TBL_ADDR_W, default 5, the action-table address width.
REQ-007 SHALL have derived localparam PKT_HDR_LEN = NUM_CONT*96+256.
REQ-008 SHALL have ports: clk in 1 (clock); aresetn in 1 (reset). Reset is synchronous and active-low.
REQ-009 SHALL have ports s_axis_tdata / tuser / tkeep / tvalid / tlast in, with widths DATA / TUSER / DATA/8 / 1 / 1; s_axis_tready out 1.
REQ-010 SHALL have ports parser_valid out 1; pkt_hdr_vec out PKT_HDR_LEN; stg_ready_in in 1.
REQ-011 SHALL have ports tbl_wr_en in 1; tbl_wr_addr in TBL_ADDR_W; tbl_wr_data in NUM_ACTS*16.
REQ-012 SHALL have ports pkt_cnt out 32 and trunc_cnt out 32, present only when PARSER_STATS_EN is defined.

Function
REQ-013 States SHALL be IDLE, CAPTURE, FLUSH, EXTRACT, OUTPUT.
- s_axis_tready=1 in IDLE, CAPTURE and FLUSH.
- s_axis_tready=0 in EXTRACT and OUTPUT.
REQ-014 A beat SHALL be accepted only when tvalid&&tready. Beat k (0-based, k<NUM_SEGS) SHALL be stored at hdr_buf[k*DATA+:DATA].
REQ-015 On the first accepted beat, hdr_buf SHALL be zeroed except beat 0, and tuser SHALL be latched.
REQ-016 Transitions:
- IDLE to CAPTURE on the first beat.
- To EXTRACT on any accepted beat with tlast (a single-beat packet goes IDLE to EXTRACT).
- To FLUSH when beat NUM_SEGS-1 is accepted without tlast.
- FLUSH discards beats and goes to EXTRACT on accepted tlast.
REQ-017 vlan_id SHALL be hdr_buf[116+:12]. The table SHALL be read at address vlan_id[4+:TBL_ADDR_W].
REQ-018 Action a SHALL be entry bits [a*16+:16], with these fields:
- [0] valid.
- [4:3] type: 01=2B, 10=4B, 11=6B, 00=none.
- [7:5] container index.
- [15:8] byte offset.
REQ-019 EXTRACT SHALL, in one cycle, write each valid action's field into its container.
- The byte at offset o is hdr_buf[o*8+:8] and becomes the container MSB (network order).
- Bytes beyond NUM_SEGS*DATA/8 SHALL read 0.
- A container index ≥ NUM_CONT SHALL be ignored.
REQ-020 If two actions target the same container, the higher action index SHALL win. Containers not written SHALL be 0.
REQ-021 pkt_hdr_vec SHALL be {6B[NUM_CONT-1:0], 4B[..], 2B[..], 115'b0, vlan_id, 1'b0, tuser_latched}, with the highest index first. It is registered on EXTRACT→OUTPUT.
REQ-022 In OUTPUT, parser_valid SHALL be held at 1 with pkt_hdr_vec stable until stg_ready_in=1. On that cycle the block SHALL go to IDLE, and parser_valid and s_axis_tready SHALL take their IDLE values next cycle.
REQ-023 Latency: tlast accepted at cycle T → EXTRACT at T+1 → parser_valid=1 at T+2 (best case).
REQ-024 A table write in the EXTRACT cycle to the address being read SHALL NOT affect that packet (old data used). The write SHALL take effect from the next cycle.

Reset
REQ-025 On aresetn=0 at a clk edge the block SHALL reset, including mid-packet:
- state=IDLE, s_axis_tready=1, parser_valid=0, pkt_hdr_vec=0.
- hdr_buf=0, all table entries=0 (all actions invalid), counters=0.
REQ-026 A packet in flight at reset SHALL be lost. The beats of its remainder after reset SHALL be treated as a new packet.

Configuration
REQ-027 With macro PARSER_STATS_EN defined, the block SHALL have the counter ports and update them as follows:
- pkt_cnt SHALL increment by 1 on each output handshake.
- trunc_cnt SHALL increment by 1 on each CAPTURE→FLUSH transition.
- Both SHALL wrap at 2^32.
- On the same cycle as an output handshake, both SHALL count independently.
REQ-028 Without PARSER_STATS_EN, the counter ports and logic SHALL be absent. All other behaviour SHALL be identical.

Verification
REQ-029 Reset state:
- Stimulus: reset, then one 2-beat packet with vlan 5 and an empty table.
- Required: parser_valid=1 at T+2; all containers 0; metadata vlan_id=5; tuser matches beat 0.
REQ-030 Field extraction:
- Stimulus: entry 0 with action0 = {offset 0, container 2, 6B, valid}; 1-beat packet with bytes 0-5 = 01..06 and vlan_id[8:4]=0.
- Required: 6B container 2 = 0x010203040506.
REQ-031 Truncated packet (NUM_SEGS=4):
- Stimulus: a 7-beat packet.
- Required: beats 4-6 are discarded; tready=1 through tlast; one output; trunc_cnt=1 when PARSER_STATS_EN.
REQ-032 Output back-pressure:
- Stimulus: hold stg_ready_in=0 for 10 cycles.
- Required: parser_valid and pkt_hdr_vec stay stable; s_axis_tready=0; after release, one handshake and tready=1 next cycle.
REQ-033 Action conflicts and out-of-range offset:
- Stimulus: actions 1 and 7 both target the 2B container 0; a further action uses offset 200 with NUM_SEGS=4.
- Required: action 7's data is in 2B container 0; the out-of-range action yields 0.
REQ-034 Mid-packet reset:
- Stimulus: assert aresetn=0 after beat 1 of a 3-beat packet.
- Required: no output; the table reads as zero; the next packet's output matches REQ-029.
